// File: rtl/deserializer_pkg.sv
// Shared constants for the UART receive path.
// Holds the widths of the oversampling prescale and edge-counter buses.
package deserializer_pkg;

    localparam int PRESCALE_W = 5;
    localparam int EDGE_CNT_W = 3;

endpackage

// File: rtl/deserializer.sv
// UART receive deserializer: shifts one sampled bit per bit period into
// P_DATA, LSB first, on the last oversample edge of each data bit.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int IN_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sampled_bit,
    input  logic                  deser_en,
    input  logic [EDGE_CNT_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [IN_width-1:0]   P_DATA
);

    logic [PRESCALE_W-1:0] edge_ext;
    logic [PRESCALE_W-1:0] last_edge;
    logic                  shift;

    // Shift on the final edge of the bit period; prescale=0 wraps to 31
    // and prescale>8 is unreachable by the 3-bit counter, so neither shifts.
    always_comb begin
        edge_ext  = {{(PRESCALE_W-EDGE_CNT_W){1'b0}}, edge_cnt};
        last_edge = prescale - {{(PRESCALE_W-1){1'b0}}, 1'b1};
        shift     = deser_en && (edge_ext == last_edge);
    end

    // New bit enters at the MSB so the first bit lands in bit 0 after a frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA <= '0;
        end else if (shift) begin
            P_DATA <= {sampled_bit, P_DATA[IN_width-1:1]};
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for the UART deserializer.
// Model keeps the history of received bits; P_DATA is its newest 8 entries.
module tb_deserializer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       sampled_bit;
    logic       deser_en;
    logic [2:0] edge_cnt;
    logic [4:0] prescale;
    logic [7:0] P_DATA;

    deserializer #(.IN_width(8)) dut (
        .CLK(CLK),
        .RST(RST),
        .sampled_bit(sampled_bit),
        .deser_en(deser_en),
        .edge_cnt(edge_cnt),
        .prescale(prescale),
        .P_DATA(P_DATA)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    bit         hist[$];
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Newest received bit is bit 7; absent history bits read as zero.
    function automatic logic [7:0] model_word();
        logic [7:0] w = '0;
        for (int i = 0; i < 8; i++)
            if (i < hist.size()) w[7-i] = hist[hist.size()-1-i];
        return w;
    endfunction

    // A bit is taken when enabled and edge_cnt is the final edge of the period.
    function automatic bit model_takes(input bit en, input int ec, input int ps);
        return en && ps >= 1 && ec == ps - 1;
    endfunction

    task automatic cyc(input bit rst_n, input bit en, input logic [2:0] ec,
                       input logic [4:0] ps, input bit b);
        @(negedge CLK);
        RST = rst_n; deser_en = en; edge_cnt = ec; prescale = ps; sampled_bit = b;
        @(posedge CLK);
        if (!rst_n) hist.delete();
        else if (model_takes(en, int'(ec), int'(ps))) hist.push_back(b);
        exp_q.push_back(model_word());
    endtask

    // Monitor: compare the registered output against every queued expectation.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            while (exp_q.size() > 0) check("p_data", P_DATA, exp_q.pop_front());
        end
    end

    bit frame[8] = '{1, 0, 1, 1, 1, 0, 0, 1};

    initial begin
        RST = 1'b0; sampled_bit = 0; deser_en = 0; edge_cnt = 0; prescale = 8;
        #2;
        check("reset_async", P_DATA, 8'h00);

        for (int i = 0; i < 5; i++)
            cyc(0, 1'($urandom), 3'($urandom), 5'($urandom), 1'($urandom));
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 3'd7, 5'd8, 1'($urandom));
        #2 check("idle_after_reset", P_DATA, 8'h00);

        foreach (frame[i]) cyc(1, 1, 3'd7, 5'd8, frame[i]);
        #2 check("frame_direct", P_DATA, 8'b1001_1101);

        for (int i = 0; i < 8; i++) cyc(1, 1, 3'd7, 5'd8, 1'(~frame[i]));
        foreach (frame[i])
            for (int e = 0; e < 8; e++)
                cyc(1, 1, 3'(e), 5'd8, (e == 7) ? frame[i] : 1'($urandom));
        #2 check("frame_gated", P_DATA, 8'b1001_1101);

        for (int i = 0; i < 10; i++) cyc(1, 0, 3'd7, 5'd8, 1'(i % 2));
        #2 check("disabled_hold", P_DATA, 8'b1001_1101);

        cyc(1, 1, 3'd7, 5'd8, 1);
        cyc(1, 1, 3'd7, 5'd8, 1);
        #2 check("over_shift", P_DATA, 8'b1110_0111);

        for (int e = 0; e < 8; e++) cyc(1, 1, 3'(e), 5'd0, 1'($urandom));
        for (int e = 0; e < 8; e++) cyc(1, 1, 3'(e), 5'd16, 1'($urandom));
        #2 check("prescale_0_16_hold", P_DATA, 8'b1110_0111);

        cyc(1, 1, 3'd0, 5'd1, 0);
        cyc(1, 1, 3'd0, 5'd1, 0);
        cyc(1, 1, 3'd0, 5'd1, 1);
        #2 check("prescale_1", P_DATA, 8'b1001_1100);

        for (int i = 0; i < 3; i++) cyc(1, 1, 3'd7, 5'd8, 1);
        @(negedge CLK);
        #2 RST = 1'b0;
        #1 check("reset_mid_frame", P_DATA, 8'h00);
        hist.delete();
        cyc(0, 1, 3'd7, 5'd8, 1);
        foreach (frame[i]) cyc(1, 1, 3'd7, 5'd8, frame[i]);
        #2 check("frame_after_reset", P_DATA, 8'b1001_1101);

        for (int i = 0; i < 400; i++) begin
            logic [4:0] ps;
            logic [2:0] ec;
            ps = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(1, 8));
            ec = ($urandom_range(0, 1) == 0) ? 3'(ps - 5'd1) : 3'($urandom);
            cyc(($urandom_range(0, 49) != 0), 1'($urandom), ec, ps, 1'($urandom));
        end

        cyc(1, 0, 3'd0, 5'd8, 0);
        @(negedge CLK);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
